// File: rtl/clock_phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and the skeleton domains it gates.
interface clock_phase_sequencer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
);
  logic              run_en;
  logic [NUM_CH-1:0] phase_en;
  logic              core_reset;
  logic [CNT_W-1:0]  frame_count;
  logic              done;

  modport master (
    input  run_en,
    output phase_en,
    output core_reset,
    output frame_count,
    output done
  );

  modport slave (
    output run_en,
    input  phase_en,
    input  core_reset,
    input  frame_count,
    input  done
  );
endinterface

// File: rtl/clock_phase_sequencer.sv
// One-cycle phase enables per domain, stretched core reset and a frame counter
// with an optional self-halt after MAX_FRAMES frames.
module clock_phase_sequencer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DIV        = 4,
  parameter int unsigned RST_HOLD   = 2,
  parameter int unsigned MAX_FRAMES = 140,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  clock_phase_sequencer_if.master   bus
);

  localparam int unsigned PH_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [NUM_CH-1:0]  phase_en_q, phase_en_d;
  logic               core_reset_q, core_reset_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               done_q, done_d;
  logic               frame_end;
  logic [CNT_W-1:0]   frame_inc;

  // State and output registers; reset overrides every other event
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_q        <= HOLD_W'(RST_HOLD);
      phase_q       <= '0;
      phase_en_q    <= '0;
      core_reset_q  <= 1'b1;
      frame_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      phase_q       <= phase_d;
      phase_en_q    <= phase_en_d;
      core_reset_q  <= core_reset_d;
      frame_count_q <= frame_count_d;
      done_q        <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    phase_d       = phase_q;
    phase_en_d    = '0;
    core_reset_d  = core_reset_q;
    frame_count_d = frame_count_q;
    done_d        = done_q;
    frame_end     = (phase_q == PH_W'(DIV - 1));
    frame_inc     = frame_count_q + CNT_W'(1);

    case (state_q)
      S_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          core_reset_d = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.run_en) begin
          // Phases at or above NUM_CH shift the bit out, leaving an idle slot
          phase_en_d = NUM_CH'(1) << phase_q;
          phase_d    = frame_end ? '0 : phase_q + PH_W'(1);
          if (frame_end) begin
            frame_count_d = frame_inc;
            if ((MAX_FRAMES != 0) && (frame_inc == CNT_W'(MAX_FRAMES))) begin
              state_d = S_HALT;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  assign bus.phase_en    = phase_en_q;
  assign bus.core_reset  = core_reset_q;
  assign bus.frame_count = frame_count_q;
  assign bus.done        = done_q;

endmodule
